// File: rtl/pingpong_unpacker_pkg.sv
// Shared types and sizing helpers for the output ping-pong unpacker.
// Bank state encoding follows the ping-pong flag convention: bit0 = holds unread data.
package pingpong_unpacker_pkg;

    localparam int unsigned BUS_W = 32;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'b00,
        BANK_FULL     = 2'b01,
        BANK_FILLING  = 2'b10,
        BANK_DRAINING = 2'b11
    } bank_state_e;

    // Elements packed into one bus word.
    function automatic int unsigned calc_epw(input int unsigned dwidth);
        return BUS_W / dwidth;
    endfunction

    // Bus words needed to drain one bank.
    function automatic int unsigned calc_wpb(input int unsigned dwidth,
                                             input int unsigned awidth_r,
                                             input int unsigned awidth_w);
        return ((32'd1 << awidth_r) * (32'd1 << awidth_w)) / calc_epw(dwidth);
    endfunction

endpackage

// File: rtl/pingpong_unpacker_if.sv
// Row-write / word-read handshake bundle between the array, the unpacker and the bus side.
interface pingpong_unpacker_if #(
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned AWIDTH_r = 2
);
    localparam int unsigned LANES = 2 ** AWIDTH_r;

    logic                      wr_acq;
    logic                      wr_rdy;
    logic [LANES*DWIDTH-1:0]   wr_data;
    logic                      rd_acq;
    logic                      rd_rdy;
    logic [31:0]               rd_data;
    logic                      rd_valid;
    logic [1:0]                bank_full;

    modport master (
        output wr_acq, wr_data, rd_acq,
        input  wr_rdy, rd_rdy, rd_data, rd_valid, bank_full
    );

    modport slave (
        input  wr_acq, wr_data, rd_acq,
        output wr_rdy, rd_rdy, rd_data, rd_valid, bank_full
    );
endinterface

// File: rtl/pingpong_unpacker_bank_ctrl.sv
// Per-bank life cycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
module pingpong_bank_ctrl
    import pingpong_unpacker_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_fill_beat,
    input  logic i_fill_done,
    input  logic i_drain_start,
    input  logic i_drain_done,
    output logic o_writable_c,
    output logic o_readable_c
);

    bank_state_e r_state;
    bank_state_e w_next;

    always_ff @(posedge clk) begin
        if (rst) r_state <= BANK_EMPTY;
        else     r_state <= w_next;
    end

    // Single-beat banks may jump straight past the intermediate states.
    always_comb begin
        w_next = r_state;
        case (r_state)
            BANK_EMPTY: begin
                if (i_fill_done)      w_next = BANK_FULL;
                else if (i_fill_beat) w_next = BANK_FILLING;
            end
            BANK_FILLING: begin
                if (i_fill_done) w_next = BANK_FULL;
            end
            BANK_FULL: begin
                if (i_drain_done)       w_next = BANK_EMPTY;
                else if (i_drain_start) w_next = BANK_DRAINING;
            end
            BANK_DRAINING: begin
                if (i_drain_done) w_next = BANK_EMPTY;
            end
            default: w_next = BANK_EMPTY;
        endcase
    end

    always_comb begin
        o_writable_c = 1'b0;
        o_readable_c = 1'b0;
        case (r_state)
            BANK_EMPTY, BANK_FILLING:  o_writable_c = 1'b1;
            BANK_FULL, BANK_DRAINING:  o_readable_c = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/pingpong_unpacker.sv
// Output ping-pong buffer: rows from the PE array are stored column-wise and
// drained as 32-bit words in linear element order, lowest element in the MSBs.
module pingpong_unpacker
    import pingpong_unpacker_pkg::*;
#(
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned AWIDTH_r = 2,
    parameter int unsigned AWIDTH_w = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    pingpong_unpacker_if.slave    bus
);

    localparam int unsigned LANES     = 2 ** AWIDTH_r;
    localparam int unsigned ROWS      = 2 ** AWIDTH_w;
    localparam int unsigned NELEM     = LANES * ROWS;
    localparam int unsigned EPW       = calc_epw(DWIDTH);
    localparam int unsigned WPB       = calc_wpb(DWIDTH, AWIDTH_r, AWIDTH_w);
    localparam int unsigned EIDX_W    = AWIDTH_r + AWIDTH_w;
    localparam int unsigned WCNT_W    = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int unsigned LAST_ROW  = ROWS - 1;
    localparam int unsigned LAST_WORD = WPB - 1;

    logic                   r_wr_sel;
    logic                   r_rd_sel;
    logic [AWIDTH_w-1:0]    r_row;
    logic [WCNT_W-1:0]      r_word;
    logic [DWIDTH-1:0]      r_mem [2][NELEM];
    logic [BUS_W-1:0]       r_rd_data;
    logic                   r_rd_valid;

    logic [1:0]             w_writable;
    logic [1:0]             w_readable;
    logic                   w_wr_fire;
    logic                   w_rd_fire;
    logic                   w_row_last;
    logic                   w_word_last;
    logic [BUS_W-1:0]       w_word;

    assign bus.wr_rdy    = w_writable[r_wr_sel];
    assign bus.rd_rdy    = w_readable[r_rd_sel];
    assign bus.bank_full = w_readable;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;

    assign w_wr_fire   = bus.wr_acq & bus.wr_rdy;
    assign w_rd_fire   = bus.rd_acq & bus.rd_rdy;
    assign w_row_last  = (r_row  == AWIDTH_w'(LAST_ROW));
    assign w_word_last = (r_word == WCNT_W'(LAST_WORD));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pingpong_bank_ctrl u_ctrl (
            .clk           (clk),
            .rst           (rst),
            .i_fill_beat   (w_wr_fire && (r_wr_sel == 1'(b))),
            .i_fill_done   (w_wr_fire && (r_wr_sel == 1'(b)) && w_row_last),
            .i_drain_start (w_rd_fire && (r_rd_sel == 1'(b))),
            .i_drain_done  (w_rd_fire && (r_rd_sel == 1'(b)) && w_word_last),
            .o_writable_c  (w_writable[b]),
            .o_readable_c  (w_readable[b])
        );
    end

    // Row and word counters plus bank pointers; pointers flip on bank completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_row    <= '0;
            r_word   <= '0;
        end else begin
            if (w_wr_fire) begin
                if (w_row_last) begin
                    r_row    <= '0;
                    r_wr_sel <= ~r_wr_sel;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end
            if (w_rd_fire) begin
                if (w_word_last) begin
                    r_word   <= '0;
                    r_rd_sel <= ~r_rd_sel;
                end else begin
                    r_word <= r_word + 1'b1;
                end
            end
        end
    end

    // Lane i of row r lands at element i*ROWS + r.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int i = 0; i < LANES; i++) begin
                r_mem[r_wr_sel][{AWIDTH_r'(i), r_row}] <= bus.wr_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        w_word = '0;
        for (int k = 0; k < EPW; k++) begin
            w_word[BUS_W-1-k*DWIDTH -: DWIDTH] =
                r_mem[r_rd_sel][EIDX_W'(32'(r_word) * EPW + 32'(k))];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) r_rd_data <= w_word;
        end
    end

endmodule

// File: doc/pingpong_unpacker.md
Name: pingpong_unpacker

Overview:
- Output-side counterpart of the input ping-pong buffer; the buffer's lane/row addressing runs in the reverse direction.
- Accepts full-width result rows (one element per PE lane) from the compute array and re-packs them into 32-bit words for the bus/DMA side.
- Two banks alternate: the array fills one bank while the bus drains the other.
- Rows are written column-wise and words are read in linear element order, so the packing is the transpose of the input buffer's write-word/read-row path.

Parameters:
- DWIDTH, 8, element width in bits; must divide 32.
- AWIDTH_r, 2, log2 of lanes per row (LANES = 2**AWIDTH_r).
- AWIDTH_w, 2, log2 of rows per bank (ROWS = 2**AWIDTH_w); ROWS*LANES*DWIDTH must be a multiple of 32.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_acq  in  1  row write request.
- wr_rdy  out  1  a row can be accepted this cycle.
- wr_data  in  LANES*DWIDTH  one row; lane i occupies bits [(i+1)*DWIDTH-1 : i*DWIDTH].
- rd_acq  in  1  word read request.
- rd_rdy  out  1  a word can be read this cycle.
- rd_data  out  32  packed word, registered.
- rd_valid  out  1  rd_data holds a newly read word.
- bank_full  out  2  per-bank status: bank holds unread data (FULL or DRAINING).

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Constants:
  - EPW = 32/DWIDTH elements per word.
  - WPB = ROWS*LANES/EPW words per bank.
- Per-bank state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Pointers wr_sel and rd_sel each select a bank; each toggles only when its side completes a bank.
- wr_rdy = state[wr_sel] is EMPTY or FILLING (combinational).
- rd_rdy = state[rd_sel] is FULL or DRAINING (combinational).
- Write:
  - Write fires on wr_acq & wr_rdy.
  - Lane i of row counter r goes to element index i*ROWS + r of bank wr_sel.
  - r increments 0..ROWS-1; the bank enters FILLING on the first beat.
  - On the beat with r == ROWS-1: bank becomes FULL, r wraps to 0, wr_sel toggles.
- Read:
  - Read fires on rd_acq & rd_rdy.
  - Word counter w (0..WPB-1) selects elements w*EPW .. w*EPW+EPW-1 of bank rd_sel.
  - The lowest element index lands in the MSBs of the word.
  - Bank enters DRAINING on the first read.
  - On the read with w == WPB-1: bank becomes EMPTY, w wraps to 0, rd_sel toggles.
- Latency:
  - rd_data and rd_valid update on the clock after the accepting edge.
  - rd_valid is high for exactly one cycle per accepted read.
  - rd_data holds its value when no read fires.
- Write-to-read: a bank completed by the final write is readable (rd_rdy high) on the next cycle. There is no bypass.
- Simultaneous events: a write into one bank and a read from the other in the same cycle are both legal and independent. wr_sel == rd_sel while both fire cannot occur, because the state guards are mutually exclusive.
- Full/empty limits:
  - Both banks FULL/DRAINING: wr_rdy = 0, and wr_acq is ignored with no state change.
  - Both banks EMPTY/FILLING: rd_rdy = 0, and rd_acq is ignored.
- Reset (also mid-operation): states EMPTY, both pointers 0, r = 0, w = 0, rd_data = 0, rd_valid = 0, bank_full = 0. Bank storage is not reset and its contents are don't-care.

Decomposition:
- Shared package holds:
  - bank state encoding: EMPTY = 2'b00, FILLING = 2'b10, FULL = 2'b01, DRAINING = 2'b11. This matches the ping-pong flag convention.
  - helper constants EPW and WPB.
- One natural sub-module, pingpong_bank_ctrl: the per-bank state machine, instantiated twice with inputs fill_done, drain_start, drain_done.
- The top level holds storage, counters, pointers and the pack mux.

Test Plan (defaults DWIDTH=8, LANES=4, ROWS=4, EPW=4, WPB=4):
- Basic pack:
  - Stimulus: write rows r=0..3 with wr_data = {8'h30+r, 8'h20+r, 8'h10+r, 8'h00+r}, then read 4 words.
  - Required: rd_data = 0x00010203, 0x10111213, 0x20212223, 0x30313233, each with a one-cycle rd_valid pulse.
- Ping-pong overlap:
  - Stimulus: fill bank0, then read bank0 while writing bank1 every cycle.
  - Required: no stalls, and bank1 data reads back correctly after bank0.
- Backpressure:
  - Stimulus: fill both banks with no reads.
  - Required: wr_rdy = 0, bank_full = 2'b11, and a 9th wr_acq is dropped. After 4 reads, wr_rdy = 1 on the next cycle.
- Empty read:
  - Stimulus: rd_acq high immediately after reset.
  - Required: rd_rdy = 0, rd_valid stays 0, and w is unchanged.
- Mid-operation reset:
  - Stimulus: assert rst after 2 rows written and 1 word read.
  - Required: next cycle shows wr_rdy = 1, rd_rdy = 0, rd_data = 0, bank_full = 0. A fresh full fill/drain then matches the basic-pack values.
- Last-row timing:
  - Stimulus: the 4th write completes.
  - Required: rd_rdy rises exactly one cycle later; the first word appears with rd_valid one cycle after its rd_acq.
